// File: rtl/audio_sd_dac_pkg.sv
// Shared constants for the stereo sigma-delta audio DAC: sample width default,
// integrator sizing and the gain ramp scale.
package audio_pkg;

  localparam int IN_W_DEF   = 6;
  localparam int GAIN_W     = 7;
  localparam int GAIN_MAX   = 64;
  localparam int GAIN_SHIFT = 6;

  // Integrators carry four guard bits over the sample width.
  function automatic int integ_w(input int in_w);
    return in_w + 4;
  endfunction

endpackage

// File: rtl/audio_sd_dac_sd_mod2.sv
// Per-channel second-order error-feedback sigma-delta modulator with
// saturating integrators and a registered 1-bit output.
module sd_mod2
  import audio_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [IN_W-1:0] xs,
  output logic            y
);

  localparam int EW = integ_w(IN_W);
  localparam int AW = IN_W + 5;
  localparam logic signed [AW-1:0] RAIL_HI = AW'(1 << (IN_W + 2));
  localparam logic signed [AW-1:0] RAIL_LO = -RAIL_HI;
  localparam logic signed [AW-1:0] FB_ONE  = AW'((1 << IN_W) - 1);

  // Clamp to the rail; the wide sum guarantees the sign is never lost.
  function automatic logic signed [EW-1:0] sat(input logic signed [AW-1:0] v);
    if (v > RAIL_HI) return EW'(RAIL_HI);
    if (v < RAIL_LO) return EW'(RAIL_LO);
    return EW'(v);
  endfunction

  logic signed [EW-1:0] e1_p2, e2_p2;
  logic                 y_p2;
  logic signed [AW-1:0] fb, xs_s, e1_sum, e2_sum;
  logic signed [EW-1:0] e1_nxt, e2_nxt;

  always_comb begin
    fb     = y_p2 ? FB_ONE : '0;
    xs_s   = AW'($signed({1'b0, xs}));
    e1_sum = AW'(e1_p2) + xs_s - fb;
    e1_nxt = sat(e1_sum);
    e2_sum = AW'(e2_p2) + AW'(e1_nxt) - fb;
    e2_nxt = sat(e2_sum);
  end

  // Stage 3: integrators and quantiser
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      e1_p2 <= '0;
      e2_p2 <= '0;
      y_p2  <= 1'b0;
    end else begin
      e1_p2 <= e1_nxt;
      e2_p2 <= e2_nxt;
      y_p2  <= !e2_nxt[EW-1] && (e2_nxt != '0);
    end
  end

  assign y = y_p2;

endmodule

// File: rtl/audio_sd_dac.sv
// Stereo second-order sigma-delta audio DAC with a soft-mute gain ramp that
// starts silent out of reset and fades in/out on the mute level.
module audio_sd_dac
  import audio_pkg::*;
#(
  parameter int IN_W     = IN_W_DEF,
  parameter int RAMP_DIV = 1024
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [IN_W-1:0] audio_l,
  input  logic [IN_W-1:0] audio_r,
  input  logic            mute,
  output logic            dac_l,
  output logic            dac_r,
  output logic            ramp_busy
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0]     PRE_LAST  = PW'(RAMP_DIV - 1);
  localparam logic [GAIN_W-1:0] GAIN_FULL = GAIN_W'(GAIN_MAX);

  // Unsigned x * gain with a full-width product, then drop the gain scale.
  function automatic logic [IN_W-1:0] scale(input logic [IN_W-1:0] x,
                                            input logic [GAIN_W-1:0] g);
    logic [IN_W+GAIN_W-1:0] prod;
    prod = {{GAIN_W{1'b0}}, x} * {{IN_W{1'b0}}, g};
    return prod[GAIN_SHIFT +: IN_W];
  endfunction

  logic [PW-1:0]     pre;
  logic [GAIN_W-1:0] gain;
  logic              pre_wrap;

  assign pre_wrap = (pre == PRE_LAST);

  // Free-running prescaler; mute direction is only consulted at wrap.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pre  <= '0;
      gain <= '0;
    end else begin
      pre <= pre_wrap ? '0 : pre + 1'b1;
      if (pre_wrap) begin
        if (!mute && (gain != GAIN_FULL)) gain <= gain + 1'b1;
        else if (mute && (gain != '0))    gain <= gain - 1'b1;
      end
    end
  end

  assign ramp_busy = mute ? (gain != '0) : (gain != GAIN_FULL);

  logic [IN_W-1:0] x_l_p0, x_r_p0;
  logic [IN_W-1:0] xs_l_p1, xs_r_p1;

  // Stage 1: input capture
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      x_l_p0 <= '0;
      x_r_p0 <= '0;
    end else begin
      x_l_p0 <= audio_l;
      x_r_p0 <= audio_r;
    end
  end

  // Stage 2: gain scaling
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      xs_l_p1 <= '0;
      xs_r_p1 <= '0;
    end else begin
      xs_l_p1 <= scale(x_l_p0, gain);
      xs_r_p1 <= scale(x_r_p0, gain);
    end
  end

  logic y_l, y_r;

  sd_mod2 #(.IN_W(IN_W)) u_mod_l (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .xs      (xs_l_p1),
    .y       (y_l)
  );

  sd_mod2 #(.IN_W(IN_W)) u_mod_r (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .xs      (xs_r_p1),
    .y       (y_r)
  );

  assign dac_l = y_l;
  assign dac_r = y_r;

endmodule

// File: tb/tb_audio_sd_dac.sv
// Bench for audio_sd_dac: integer behavioural model checked every cycle, plus
// directed ramp, density, step and reset vectors with hand-derived targets.
module tb_audio_sd_dac;

  localparam int IN_W = 6;
  localparam int RD   = 4;
  localparam int FS   = 63;
  localparam int RAIL = 256;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] audio_l = '0;
  logic [5:0] audio_r = '0;
  logic       mute    = 1'b0;
  logic       dac_l, dac_r, ramp_busy;

  audio_sd_dac #(.IN_W(IN_W), .RAMP_DIV(RD)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .audio_l   (audio_l),
    .audio_r   (audio_r),
    .mute      (mute),
    .dac_l     (dac_l),
    .dac_r     (dac_r),
    .ramp_busy (ramp_busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    n_vec++;
    if (act > exp + tol || act < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Behavioural model: gain ramp rule, 2-clock scaling pipe, integer modulator.
  function automatic int clampi(input int v);
    return (v > RAIL) ? RAIL : ((v < -RAIL) ? -RAIL : v);
  endfunction
  function automatic int nxt_e1(input int e1, input int xs, input bit y);
    return clampi(e1 + xs - (y ? FS : 0));
  endfunction
  function automatic int nxt_e2(input int e2, input int e1, input int xs, input bit y);
    return clampi(e2 + nxt_e1(e1, xs, y) - (y ? FS : 0));
  endfunction
  function automatic int nxt_gain(input int g, input int pres, input bit mu);
    if (pres != RD - 1) return g;
    if (!mu && g < 64) return g + 1;
    if (mu && g > 0) return g - 1;
    return g;
  endfunction

  int m_pres = 0, m_gain = 0;
  int m_x_l = 0, m_x_r = 0, m_xs_l = 0, m_xs_r = 0;
  int m_e1_l = 0, m_e2_l = 0, m_e1_r = 0, m_e2_r = 0;
  bit m_y_l = 0, m_y_r = 0;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_pres <= 0; m_gain <= 0;
      m_x_l <= 0; m_x_r <= 0; m_xs_l <= 0; m_xs_r <= 0;
      m_e1_l <= 0; m_e2_l <= 0; m_e1_r <= 0; m_e2_r <= 0;
      m_y_l <= 0; m_y_r <= 0;
    end else begin
      m_pres <= (m_pres + 1) % RD;
      m_gain <= nxt_gain(m_gain, m_pres, mute);
      m_x_l  <= int'(audio_l);
      m_x_r  <= int'(audio_r);
      m_xs_l <= (m_x_l * m_gain) / 64;
      m_xs_r <= (m_x_r * m_gain) / 64;
      m_e1_l <= nxt_e1(m_e1_l, m_xs_l, m_y_l);
      m_e2_l <= nxt_e2(m_e2_l, m_e1_l, m_xs_l, m_y_l);
      m_y_l  <= nxt_e2(m_e2_l, m_e1_l, m_xs_l, m_y_l) > 0;
      m_e1_r <= nxt_e1(m_e1_r, m_xs_r, m_y_r);
      m_e2_r <= nxt_e2(m_e2_r, m_e1_r, m_xs_r, m_y_r);
      m_y_r  <= nxt_e2(m_e2_r, m_e1_r, m_xs_r, m_y_r) > 0;
    end
  end

  bit chk_en = 0;

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("dac_l", int'(dac_l), int'(m_y_l));
      check("dac_r", int'(dac_r), int'(m_y_r));
      check("ramp_busy", int'(ramp_busy), mute ? int'(m_gain != 0) : int'(m_gain != 64));
      check_tol("e1_l_range", int'(dut.u_mod_l.e1_p2), 0, RAIL);
      check_tol("e2_l_range", int'(dut.u_mod_l.e2_p2), 0, RAIL);
      check_tol("e1_r_range", int'(dut.u_mod_r.e1_p2), 0, RAIL);
      check_tol("e2_r_range", int'(dut.u_mod_r.e2_p2), 0, RAIL);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic measure(input int settle, input int len, output int ones_l, output int ones_r);
    ticks(settle);
    ones_l = 0;
    ones_r = 0;
    for (int i = 0; i < len; i++) begin
      tick();
      ones_l += int'(dac_l);
      ones_r += int'(dac_r);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ol, or_;
    int waited;

    // Reset held with random inputs
    reset_n = 1'b0;
    mute    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      audio_l = 6'($urandom);
      audio_r = 6'($urandom);
      tick();
    end
    check("rst_dac_l", int'(dac_l), 0);
    check("rst_dac_r", int'(dac_r), 0);
    check("rst_gain", int'(dut.gain), 0);
    check("rst_busy", int'(ramp_busy), 1);

    // Ramp-in: 64 steps of RD clocks
    audio_l = 6'd32;
    audio_r = 6'd32;
    reset_n = 1'b1;
    chk_en  = 1;
    ticks(255);
    check("ramp_gain_255", int'(dut.gain), 63);
    check("ramp_busy_255", int'(ramp_busy), 1);
    tick();
    check("ramp_gain_256", int'(dut.gain), 64);
    check("ramp_busy_256", int'(ramp_busy), 0);

    // Density at full gain
    measure(200, 6300, ol, or_);
    check_tol("dens32_l", ol, 3200, 2);
    check_tol("dens32_r", or_, 3200, 2);
    audio_l = 6'd63;
    measure(200, 6300, ol, or_);
    check_tol("dens63_l", ol, 6300, 2);
    audio_l = 6'd0;
    measure(200, 6300, ol, or_);
    check("dens0_l", ol, 0);

    // Channel independence
    audio_l = 6'd10;
    audio_r = 6'd50;
    measure(200, 6300, ol, or_);
    check_tol("dens10_l", ol, 1000, 2);
    check_tol("dens50_r", or_, 5000, 2);

    // Step 0<->63 every 3 clocks
    ol = 0;
    for (int i = 0; i < 10000; i++) begin
      audio_l = ((i / 3) % 2 == 0) ? 6'd0 : 6'd63;
      audio_r = audio_l;
      tick();
      ol += int'(dac_l);
    end
    check_tol("step_dens_l", ol, 5000, 50);

    // Ramp-out
    audio_l = 6'd63;
    audio_r = 6'd20;
    mute    = 1'b1;
    ticks(256);
    check("mute_gain", int'(dut.gain), 0);
    check("mute_busy", int'(ramp_busy), 0);
    ticks(50);

    // Ramp back up and reset at gain 37
    mute   = 1'b0;
    waited = 0;
    while (int'(dut.gain) != 37 && waited < 400) begin
      tick();
      waited++;
    end
    check("reach_gain37", int'(dut.gain), 37);
    for (int i = 0; i < 4 && dac_l == 1'b0; i++) tick();
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_dac_l", int'(dac_l), 0);
    check("midrst_dac_r", int'(dac_r), 0);
    check("midrst_gain", int'(dut.gain), 0);
    check("midrst_busy", int'(ramp_busy), 1);
    ticks(3);
    reset_n = 1'b1;
    ticks(3);
    check("restart_gain_3", int'(dut.gain), 0);
    tick();
    check("restart_gain_4", int'(dut.gain), 1);
    ticks(20);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
